// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared types and constants for the instruction trace monitor.
//               Holds the monitor state encoding and the trace entry width.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

  // Default field widths of one trace entry {PC, IR}
  localparam int unsigned TRACE_PC_W = 8;
  localparam int unsigned TRACE_IR_W = 16;

  // Width of one stored entry: program counter concatenated with instruction
  function automatic int unsigned trace_entry_w(input int unsigned pc_w,
                                                input int unsigned ir_w);
    return pc_w + ir_w;
  endfunction

  localparam int unsigned TRACE_ENTRY_W = trace_entry_w(TRACE_PC_W, TRACE_IR_W);

  // Monitor state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } trace_state_e;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Circular trace buffer with first-word fall-through read,
//               entry count, sticky overflow flag and selectable full-buffer
//               policy (drop oldest or drop newest).
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned DEPTH     = 8,
  parameter bit          OVERWRITE = 1'b1,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_wr;
  logic             w_rd;
  logic             w_ovf_set;
  logic [CNT_W-1:0] w_count_next;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A requested pop only counts when something is held; a simultaneous pop
  // frees the slot so a push into a full buffer is then not an overflow.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_ovf_set = i_push && w_full && !w_do_pop;
  assign w_wr      = i_push && (!w_full || w_do_pop || OVERWRITE);
  assign w_rd      = w_do_pop || (w_ovf_set && OVERWRITE);

  // Entry count follows the net effect of the write and read pointer moves
  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_rd) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_wr && w_rd) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Pointers, count and sticky overflow; clear wins over any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + PTR_W'(1);
      if (w_rd) r_rp <= r_rp + PTR_W'(1);
      r_count <= w_count_next;
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  // Entry storage; contents are only visible while the count is non-zero
  always_ff @(posedge clk) begin
    if (w_wr && !i_clr) r_mem[r_wp] <= i_push_data;
  end

  assign o_rd_data  = w_empty ? '0 : r_mem[r_rp];
  assign o_rd_valid = !w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : trace_monitor
// Description : Watches a processor's PC/IR, records each new PC with its
//               instruction into a trace buffer, and stops on a halt word or
//               after a cycle limit.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_monitor
  import trace_pkg::*;
#(
  parameter int unsigned    IR_W      = TRACE_IR_W,
  parameter int unsigned    PC_W      = TRACE_PC_W,
  parameter int unsigned    DEPTH     = 8,
  parameter logic [IR_W-1:0] HALT_WORD = 16'h6000,
  parameter int unsigned    TIMEOUT   = 1000,
  parameter bit             OVERWRITE = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [IR_W-1:0]         IR_In,
  input  logic [PC_W-1:0]         PC_In,
  input  logic                    Rd_En,
  output logic [PC_W+IR_W-1:0]    Rd_Data,
  output logic                    Rd_Valid,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Halted,
  output logic                    Timed_Out,
  output logic                    Overflow,
  output logic [31:0]             Cycles
);

  localparam int unsigned c_ENTRY_W = trace_entry_w(PC_W, IR_W);

  trace_state_e    r_state;
  trace_state_e    w_state_next;
  logic [31:0]     r_cycles;
  logic [31:0]     w_cycles_inc;
  logic            r_first;
  logic [PC_W-1:0] r_last_pc;
  logic            w_run;
  logic            w_halted;
  logic            w_timed_out;
  logic            w_push;

  assign w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;

  // Start owns its edge entirely, so a push can never coincide with the clear
  assign w_push = w_run && !Start && (r_first || (PC_In != r_last_pc));

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: halt has priority over the cycle limit at the same edge
  always_comb begin
    w_state_next = r_state;
    if (Start) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (IR_In == HALT_WORD)             w_state_next = ST_HALTED;
      else if (w_cycles_inc == TIMEOUT)   w_state_next = ST_TIMEOUT;
    end
  end

  // State-decoded outputs
  always_comb begin
    w_run       = 1'b0;
    w_halted    = 1'b0;
    w_timed_out = 1'b0;
    case (r_state)
      ST_RUN:     w_run       = 1'b1;
      ST_HALTED:  w_halted    = 1'b1;
      ST_TIMEOUT: w_timed_out = 1'b1;
      default:    ;
    endcase
  end

  // Cycle counter, first-edge marker and last pushed PC
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cycles  <= '0;
      r_first   <= 1'b0;
      r_last_pc <= '0;
    end else if (Start) begin
      r_cycles  <= '0;
      r_first   <= 1'b1;
    end else begin
      if (w_run)  r_cycles  <= w_cycles_inc;
      if (w_run)  r_first   <= 1'b0;
      if (w_push) r_last_pc <= PC_In;
    end
  end

  trace_fifo #(
    .WIDTH     (c_ENTRY_W),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk         (Clk),
    .rst_n       (Reset),
    .i_clr       (Start),
    .i_push      (w_push),
    .i_push_data ({PC_In, IR_In}),
    .i_pop       (Rd_En),
    .o_rd_data   (Rd_Data),
    .o_rd_valid  (Rd_Valid),
    .o_count     (Count),
    .o_overflow  (Overflow)
  );

  assign Halted    = w_halted;
  assign Timed_Out = w_timed_out;
  assign Cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_trace_monitor.sv
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_trace_monitor
// Description : Self-checking bench for trace_monitor. Three instances share
//               stimulus: 0 = defaults, 1 = drop-newest, 2 = TIMEOUT of 20.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_monitor;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] IR_In = '0;
  logic [7:0]  PC_In = '0;
  logic        Rd_En = 1'b0;

  logic [23:0] rd_data_o [3];
  logic        rd_valid_o [3];
  logic [3:0]  cnt_o [3];
  logic        halt_o [3];
  logic        tout_o [3];
  logic        ovf_o [3];
  logic [31:0] cyc_o [3];

  int tests = 0;
  int fails = 0;

  // Reference model state, one slot per instance
  logic [23:0] mq [3][$];
  longint      m_cyc [3];
  bit          m_run [3], m_first [3], m_halt [3], m_tout [3], m_ovf [3];
  logic [7:0]  m_lastpc [3];

  always #5 Clk = ~Clk;

  trace_monitor #(.IR_W(16), .PC_W(8), .DEPTH(8), .HALT_WORD(16'h6000),
                  .TIMEOUT(1000), .OVERWRITE(1'b1)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR_In(IR_In), .PC_In(PC_In),
    .Rd_En(Rd_En), .Rd_Data(rd_data_o[0]), .Rd_Valid(rd_valid_o[0]),
    .Count(cnt_o[0]), .Halted(halt_o[0]), .Timed_Out(tout_o[0]),
    .Overflow(ovf_o[0]), .Cycles(cyc_o[0]));

  trace_monitor #(.IR_W(16), .PC_W(8), .DEPTH(8), .HALT_WORD(16'h6000),
                  .TIMEOUT(1000), .OVERWRITE(1'b0)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR_In(IR_In), .PC_In(PC_In),
    .Rd_En(Rd_En), .Rd_Data(rd_data_o[1]), .Rd_Valid(rd_valid_o[1]),
    .Count(cnt_o[1]), .Halted(halt_o[1]), .Timed_Out(tout_o[1]),
    .Overflow(ovf_o[1]), .Cycles(cyc_o[1]));

  trace_monitor #(.IR_W(16), .PC_W(8), .DEPTH(8), .HALT_WORD(16'h6000),
                  .TIMEOUT(20), .OVERWRITE(1'b1)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR_In(IR_In), .PC_In(PC_In),
    .Rd_En(Rd_En), .Rd_Data(rd_data_o[2]), .Rd_Valid(rd_valid_o[2]),
    .Count(cnt_o[2]), .Halted(halt_o[2]), .Timed_Out(tout_o[2]),
    .Overflow(ovf_o[2]), .Cycles(cyc_o[2]));

  function automatic longint m_timeout(input int k);
    return (k == 2) ? 64'd20 : 64'd1000;
  endfunction

  function automatic bit m_overwrite(input int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      m_cyc[k] = 0; m_run[k] = 0; m_first[k] = 0;
      m_halt[k] = 0; m_tout[k] = 0; m_ovf[k] = 0; m_lastpc[k] = '0;
    end
  endtask

  // One rising edge of the behavioural trace monitor
  task automatic model_step(input logic st, input logic [15:0] ir,
                            input logic [7:0] pc, input logic rd);
    bit push, pop;
    for (int k = 0; k < 3; k++) begin
      if (st) begin
        mq[k].delete();
        m_cyc[k] = 0; m_halt[k] = 0; m_tout[k] = 0; m_ovf[k] = 0;
        m_run[k] = 1; m_first[k] = 1;
      end else begin
        push = m_run[k] && (m_first[k] || pc != m_lastpc[k]);
        pop  = rd && (mq[k].size() > 0);
        if (m_run[k]) begin
          if (m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k] = m_cyc[k] + 1;
          m_first[k] = 0;
          if (ir == 16'h6000) begin
            m_halt[k] = 1; m_run[k] = 0;
          end else if (m_cyc[k] == m_timeout(k)) begin
            m_tout[k] = 1; m_run[k] = 0;
          end
        end
        if (pop) void'(mq[k].pop_front());
        if (push) begin
          m_lastpc[k] = pc;
          if (mq[k].size() < 8) begin
            mq[k].push_back({pc, ir});
          end else begin
            m_ovf[k] = 1;
            if (m_overwrite(k)) begin
              void'(mq[k].pop_front());
              mq[k].push_back({pc, ir});
            end
          end
        end
      end
    end
  endtask

  // Apply inputs for one cycle; return 1ns after the edge with model updated
  task automatic tick(input logic st, input logic [15:0] ir,
                      input logic [7:0] pc, input logic rd);
    Start = st; IR_In = ir; PC_In = pc; Rd_En = rd;
    @(posedge Clk);
    if (Reset) model_step(st, ir, pc, rd);
    else       model_reset();
    #1;
    Start = 1'b0; Rd_En = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({rd_data_o[k], rd_valid_o[k], cnt_o[k], halt_o[k], tout_o[k], ovf_o[k], cyc_o[k]} !== '0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got data=%h valid=%b cnt=%0d halt=%b tout=%b ovf=%b cyc=%0d, want all 0",
                 k, rd_data_o[k], rd_valid_o[k], cnt_o[k], halt_o[k], tout_o[k], ovf_o[k], cyc_o[k]);
      end
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic test_halt_program();
    logic [23:0] exp_rd [3];
    exp_rd[0] = 24'h001234; exp_rd[1] = 24'h015678; exp_rd[2] = 24'h026000;
    tick(1'b1, 16'h0000, 8'h00, 1'b0);
    tick(1'b0, 16'h1234, 8'h00, 1'b0);
    tick(1'b0, 16'h5678, 8'h01, 1'b0);
    tick(1'b0, 16'h6000, 8'h02, 1'b0);
    tests++;
    if (halt_o[0] !== 1'b1 || cnt_o[0] !== 4'd3 || cyc_o[0] !== 32'd3) begin
      fails++;
      $display("FAIL halt_edge: got halt=%b cnt=%0d cyc=%0d, want 1/3/3", halt_o[0], cnt_o[0], cyc_o[0]);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000, 8'(8'h40 + i), 1'b0);
    tests++;
    if (cyc_o[0] !== 32'd3 || cnt_o[0] !== 4'd3 || halt_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL halt_hold: got cyc=%0d cnt=%0d halt=%b, want 3/3/1", cyc_o[0], cnt_o[0], halt_o[0]);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rd_data_o[0] !== exp_rd[i] || rd_valid_o[0] !== 1'b1) begin
        fails++;
        $display("FAIL halt_read[%0d]: got %h valid=%b, want %h", i, rd_data_o[0], rd_valid_o[0], exp_rd[i]);
      end
      tick(1'b0, 16'h0000, 8'h40, 1'b1);
    end
  endtask

  task automatic test_overflow();
    tick(1'b1, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 16'h0000, 8'(i), 1'b0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (cnt_o[k] !== 4'd8 || ovf_o[k] !== 1'b1) begin
        fails++;
        $display("FAIL overflow_flags[%0d]: got cnt=%0d ovf=%b, want 8/1", k, cnt_o[k], ovf_o[k]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rd_data_o[0][23:16] !== 8'(i + 2) || rd_data_o[1][23:16] !== 8'(i)) begin
        fails++;
        $display("FAIL overflow_read[%0d]: got pc0=%h pc1=%h, want %h/%h",
                 i, rd_data_o[0][23:16], rd_data_o[1][23:16], 8'(i + 2), 8'(i));
      end
      tick(1'b0, 16'h0000, 8'h09, 1'b1);
    end
    tick(1'b0, 16'h0000, 8'h09, 1'b1);
    tests++;
    if (cnt_o[0] !== 4'd0 || rd_valid_o[0] !== 1'b0 || rd_data_o[0] !== 24'h0) begin
      fails++;
      $display("FAIL empty_pop: got cnt=%0d valid=%b data=%h, want 0/0/0", cnt_o[0], rd_valid_o[0], rd_data_o[0]);
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, 16'h0000, 8'h05, 1'b0);
    for (int i = 0; i < 25; i++) tick(1'b0, 16'h0000, 8'h05, 1'b0);
    tests++;
    if (cnt_o[2] !== 4'd1 || rd_data_o[2] !== 24'h050000 || tout_o[2] !== 1'b1 ||
        cyc_o[2] !== 32'd20 || halt_o[2] !== 1'b0) begin
      fails++;
      $display("FAIL timeout: got cnt=%0d data=%h tout=%b cyc=%0d halt=%b, want 1/050000/1/20/0",
               cnt_o[2], rd_data_o[2], tout_o[2], cyc_o[2], halt_o[2]);
    end
    tests++;
    if (cyc_o[0] !== 32'd25 || tout_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout: got cyc=%0d tout=%b, want 25/0", cyc_o[0], tout_o[0]);
    end
  endtask

  task automatic test_full_push_pop();
    tick(1'b1, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 16'hABCD, 8'(8'h10 + i), 1'b0);
    tick(1'b0, 16'hBEEF, 8'h18, 1'b1);
    tests++;
    if (cnt_o[0] !== 4'd8 || ovf_o[0] !== 1'b0 || rd_data_o[0] !== 24'h11ABCD) begin
      fails++;
      $display("FAIL full_push_pop: got cnt=%0d ovf=%b head=%h, want 8/0/11abcd", cnt_o[0], ovf_o[0], rd_data_o[0]);
    end
    for (int i = 0; i < 7; i++) tick(1'b0, 16'h0000, 8'h18, 1'b1);
    tests++;
    if (cnt_o[0] !== 4'd1 || rd_data_o[0] !== 24'h18BEEF) begin
      fails++;
      $display("FAIL full_newest: got cnt=%0d data=%h, want 1/18beef", cnt_o[0], rd_data_o[0]);
    end
  endtask

  task automatic test_start_with_read();
    tick(1'b1, 16'h0000, 8'h18, 1'b1);
    tests++;
    if (cnt_o[0] !== 4'd0 || rd_valid_o[0] !== 1'b0 || cyc_o[0] !== 32'd0 || ovf_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL start_read: got cnt=%0d valid=%b cyc=%0d ovf1=%b, want 0/0/0/0",
               cnt_o[0], rd_valid_o[0], cyc_o[0], ovf_o[1]);
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 16'h0000, 8'h00, 1'b0);
    for (int i = 1; i <= 3; i++) tick(1'b0, 16'h0101, 8'(i), 1'b0);
    tests++;
    if (cnt_o[0] !== 4'd3) begin
      fails++;
      $display("FAIL pre_reset_count: got %0d, want 3", cnt_o[0]);
    end
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({rd_data_o[k], rd_valid_o[k], cnt_o[k], halt_o[k], tout_o[k], ovf_o[k], cyc_o[k]} !== '0) begin
        fails++;
        $display("FAIL async_reset[%0d]: got data=%h valid=%b cnt=%0d cyc=%0d, want all 0",
                 k, rd_data_o[k], rd_valid_o[k], cnt_o[k], cyc_o[k]);
      end
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    tick(1'b0, 16'h0000, 8'h07, 1'b0);
    tests++;
    if (cnt_o[0] !== 4'd0 || cyc_o[0] !== 32'd0) begin
      fails++;
      $display("FAIL idle_after_reset: got cnt=%0d cyc=%0d, want 0/0", cnt_o[0], cyc_o[0]);
    end
    tick(1'b1, 16'h0000, 8'h07, 1'b0);
    tick(1'b0, 16'h2222, 8'h04, 1'b0);
    tests++;
    if (cnt_o[0] !== 4'd1 || cyc_o[0] !== 32'd1 || rd_data_o[0] !== 24'h042222) begin
      fails++;
      $display("FAIL restart: got cnt=%0d cyc=%0d data=%h, want 1/1/042222", cnt_o[0], cyc_o[0], rd_data_o[0]);
    end
  endtask

  task automatic test_random();
    logic        st, rd;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [23:0] exp_d;
    for (int n = 0; n < 1500; n++) begin
      st = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 2) == 0);
      pc = 8'($urandom_range(0, 5));
      ir = ($urandom_range(0, 29) == 0) ? 16'h6000 : 16'($urandom_range(0, 16'h5FFF));
      tick(st, ir, pc, rd);
      for (int k = 0; k < 3; k++) begin
        exp_d = (mq[k].size() > 0) ? mq[k][0] : 24'h0;
        tests++;
        if (cnt_o[k] !== 4'(mq[k].size()) || rd_valid_o[k] !== (mq[k].size() > 0) || rd_data_o[k] !== exp_d) begin
          fails++;
          $display("FAIL rand_fifo[%0d] n=%0d: got cnt=%0d valid=%b data=%h, want %0d/%b/%h",
                   k, n, cnt_o[k], rd_valid_o[k], rd_data_o[k], mq[k].size(), mq[k].size() > 0, exp_d);
        end
        tests++;
        if (halt_o[k] !== m_halt[k] || tout_o[k] !== m_tout[k] || ovf_o[k] !== m_ovf[k] ||
            cyc_o[k] !== 32'(m_cyc[k])) begin
          fails++;
          $display("FAIL rand_status[%0d] n=%0d: got halt=%b tout=%b ovf=%b cyc=%0d, want %b/%b/%b/%0d",
                   k, n, halt_o[k], tout_o[k], ovf_o[k], cyc_o[k], m_halt[k], m_tout[k], m_ovf[k], m_cyc[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt_program();
    test_overflow();
    test_timeout();
    test_full_push_pop();
    test_start_with_read();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
